// File: rtl/rbot_pkg.sv
// Shared cube-robot definitions: move codes, face indices and the move_player state encoding.
package rbot_pkg;

    localparam logic [3:0] MOVE_R  = 4'd2;
    localparam logic [3:0] MOVE_RI = 4'd3;
    localparam logic [3:0] MOVE_U  = 4'd4;
    localparam logic [3:0] MOVE_UI = 4'd5;
    localparam logic [3:0] MOVE_F  = 4'd6;
    localparam logic [3:0] MOVE_FI = 4'd7;
    localparam logic [3:0] MOVE_L  = 4'd8;
    localparam logic [3:0] MOVE_LI = 4'd9;
    localparam logic [3:0] MOVE_B  = 4'd10;
    localparam logic [3:0] MOVE_BI = 4'd11;
    localparam logic [3:0] MOVE_D  = 4'd12;
    localparam logic [3:0] MOVE_DI = 4'd13;

    localparam logic [3:0] MOVE_MIN = MOVE_R;
    localparam logic [3:0] MOVE_MAX = MOVE_DI;

    localparam int FACE_U = 0;
    localparam int FACE_R = 1;
    localparam int FACE_F = 2;
    localparam int FACE_D = 3;
    localparam int FACE_L = 4;
    localparam int FACE_B = 5;

    typedef enum logic [2:0] {
        IDLE,
        LOADED,
        FETCH,
        ISSUE,
        WAIT_DONE,
        GAP,
        PAUSE,
        DONE
    } player_state_t;

endpackage

// File: rtl/move_player_if.sv
// Issue/acknowledge handshake between move_player (master) and the stepper driver (slave).
interface move_player_if #(
    parameter int MOVE_W = 4
);
    logic              move_start;
    logic [MOVE_W-1:0] next_move;
    logic              move_done;

    modport master (
        output move_start,
        output next_move,
        input  move_done
    );

    modport slave (
        input  move_start,
        input  next_move,
        output move_done
    );
endinterface

// File: rtl/move_player_timer.sv
// move_timer: saturating down-counter reloaded with MAX_VAL; expired while the count sits at zero.
module move_timer #(
    parameter int MAX_VAL = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic load,
    input  logic enable,
    output logic expired
);

    localparam int CNT_BITS = $clog2(MAX_VAL) + 1;

    logic [CNT_BITS-1:0] count_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= CNT_BITS'(MAX_VAL);
        end else if (enable && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/move_player.sv
// Move playback engine: walks a latched move list and hands each valid code to the stepper driver.
module move_player
    import rbot_pkg::*;
#(
    parameter int MAX_MOVES      = 50,
    parameter int MOVE_W         = 4,
    parameter int CNT_W          = 8,
    parameter int GAP_CYCLES     = 250000,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [MAX_MOVES*MOVE_W-1:0] seq_in,
    input  logic [CNT_W-1:0]            num_moves,
    input  logic                        load,
    input  logic                        go,
    input  logic                        step_mode,
    input  logic                        step_req,
    input  logic                        abort,
    move_player_if.master               drv,
    output logic [CNT_W-1:0]            curr_step,
    output logic [CNT_W-1:0]            skip_count,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic                        aborted
);

    localparam int IDX_W = (MAX_MOVES > 1) ? $clog2(MAX_MOVES) : 1;

    player_state_t state_q, state_d;

    logic [MOVE_W-1:0] seq_mem [MAX_MOVES];
    logic [CNT_W-1:0]  length_q;
    logic [MOVE_W-1:0] next_move_q;
    logic              step_mode_q;
    logic              abort_pending_q;
    logic              done_q1, done_q2;

    logic [MOVE_W-1:0] fetch_code;
    logic              fetch_valid;
    logic              at_end;
    logic              ack_rise;
    logic              pend_now;
    logic              load_accept;
    logic              set_aborted;
    logic              move_start_c;
    logic              gap_load, gap_en, gap_expired;
    logic              tmo_load, tmo_en, tmo_expired;

    assign fetch_code  = seq_mem[IDX_W'(curr_step)];
    assign fetch_valid = (fetch_code >= MOVE_W'(MOVE_MIN)) && (fetch_code <= MOVE_W'(MOVE_MAX));
    assign at_end      = (curr_step == length_q);
    assign ack_rise    = done_q1 & ~done_q2;
    assign pend_now    = abort_pending_q | abort;

    move_timer #(.MAX_VAL(GAP_CYCLES)) u_gap_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (gap_load),
        .enable  (gap_en),
        .expired (gap_expired)
    );

    move_timer #(.MAX_VAL(TIMEOUT_CYCLES)) u_timeout_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (tmo_load),
        .enable  (tmo_en),
        .expired (tmo_expired)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (load) state_d = LOADED;
            end
            LOADED: begin
                if (abort)   state_d = DONE;
                else if (go) state_d = step_mode ? PAUSE : FETCH;
            end
            FETCH: begin
                if (abort || at_end) state_d = DONE;
                else if (fetch_valid) state_d = ISSUE;
            end
            ISSUE: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (ack_rise)         state_d = GAP;
                else if (tmo_expired) state_d = DONE;
            end
            GAP: begin
                if (gap_expired) begin
                    if (pend_now)         state_d = DONE;
                    else if (step_mode_q) state_d = PAUSE;
                    else                  state_d = FETCH;
                end
            end
            PAUSE: begin
                if (abort || at_end) state_d = DONE;
                else if (step_req)   state_d = FETCH;
            end
            DONE: begin
                if (load) state_d = LOADED;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        move_start_c = (state_q == ISSUE);
        busy         = !(state_q inside {IDLE, LOADED, DONE});
        done         = (state_q == DONE);
        load_accept  = load && (state_q inside {IDLE, DONE});
        gap_load     = (state_q == WAIT_DONE) && ack_rise;
        gap_en       = (state_q == GAP);
        tmo_load     = (state_q == ISSUE);
        tmo_en       = (state_q == WAIT_DONE);
        set_aborted  = (abort && (state_q inside {LOADED, FETCH, PAUSE})) ||
                       (pend_now && (state_d == DONE) && (state_q inside {WAIT_DONE, GAP}));
    end

    // The move list has no reset: it is only read after a load has filled it.
    always_ff @(posedge clock) begin
        if (load_accept) begin
            for (int i = 0; i < MAX_MOVES; i++) begin
                seq_mem[i] <= seq_in[i*MOVE_W +: MOVE_W];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            length_q        <= '0;
            curr_step       <= '0;
            skip_count      <= '0;
            error           <= 1'b0;
            aborted         <= 1'b0;
            abort_pending_q <= 1'b0;
            step_mode_q     <= 1'b0;
            next_move_q     <= '0;
            done_q1         <= 1'b0;
            done_q2         <= 1'b0;
        end else begin
            done_q1 <= drv.move_done;
            done_q2 <= done_q1;

            if (load_accept) begin
                length_q        <= (num_moves > CNT_W'(MAX_MOVES)) ? CNT_W'(MAX_MOVES) : num_moves;
                curr_step       <= '0;
                skip_count      <= '0;
                error           <= 1'b0;
                aborted         <= 1'b0;
                abort_pending_q <= 1'b0;
            end

            if ((state_q == LOADED) && go) begin
                step_mode_q <= step_mode;
            end

            if ((state_q == FETCH) && !abort && !at_end) begin
                if (fetch_valid) begin
                    next_move_q <= fetch_code;
                end else begin
                    curr_step <= curr_step + 1'b1;
                    if (skip_count != '1) skip_count <= skip_count + 1'b1;
                end
            end

            // Advance only on an acknowledge; a timeout leaves the index on the failed move.
            if (state_q == WAIT_DONE) begin
                if (ack_rise)         curr_step <= curr_step + 1'b1;
                else if (tmo_expired) error     <= 1'b1;
            end

            if (abort && (state_q inside {ISSUE, WAIT_DONE, GAP})) begin
                abort_pending_q <= 1'b1;
            end

            if (set_aborted) begin
                aborted <= 1'b1;
            end
        end
    end

    assign drv.move_start = move_start_c;
    assign drv.next_move  = next_move_q;

endmodule
